sdram_port_arbiter: RTL

//  Two-master round-robin arbiter that shares the single SDRAM controller Avalon-MM slave

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/arb_id_fifo.sv | 67 ++++++
 rtl/sdram_port_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter.
//   id_t        : master identifier carried through the read-tracking FIFO
//   M_CPU/M_AUX : IDs of the Plasma CPU data port (m0) and the DMA/HPS master (m1)
//   arb_state_t : command-lock state of the arbiter
package sdram_arb_pkg;

    typedef logic id_t;

    localparam id_t M_CPU = 1'b0;
    localparam id_t M_AUX = 1'b1;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_id_fifo.sv
// Read-tracking FIFO: holds the issuer ID of every accepted, not-yet-returned read.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push, push_id   : enqueue the ID of an accepted read
//   pop             : dequeue the head (one read beat returned)
//   head_id         : ID of the oldest outstanding read
//   full, empty     : occupancy flags
//   count           : number of entries, 0..DEPTH
// A push while full is only honoured when a pop happens in the same cycle.
module arb_id_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  id_t                      push_id,
    input  logic                     pop,
    output id_t                      head_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_MASK = PW'(DEPTH - 1);

    id_t            mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign head_id = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= M_CPU;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= (wr_ptr + 1'b1) & PTR_MASK;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr + 1'b1) & PTR_MASK;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller Avalon-MM slave.
// m0 = Plasma CPU data port, m1 = DMA / HPS bridge. Read beats are routed back to
// their issuer through an in-order ID FIFO.
// Ports:
//   clk, reset                        : clock, asynchronous active-high reset
//   mN_address/read/write/writedata/byteenable : master N command (N = 0,1)
//   mN_waitrequest                    : stall to master N
//   mN_readdata, mN_readdatavalid     : registered read response to master N
//   s_address/read/write/writedata/byteenable  : command to the controller
//   s_waitrequest, s_readdata, s_readdatavalid : controller handshake / response
//   err_unexp_rdv                     : sticky, read beat seen with nothing outstanding
//
// state     | meaning
// ST_OPEN   | free to arbitrate each cycle (round-robin on last_grant)
// ST_LOCKED | a granted command was stalled; grant held on lock_id until accepted
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4
)
(
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic                  s_readdatavalid,

    output logic                  err_unexp_rdv
);

    localparam int CW = $clog2(MAX_PENDING) + 1;

    arb_state_t         state;
    id_t                lock_id;
    id_t                last_grant;
    id_t                grant;
    logic               grant_valid;
    logic               req0;
    logic               req1;
    logic               g_read;
    logic               g_write;
    logic               read_blocked;
    logic               accept;
    logic               rdv_pop;
    logic               rdv_unexp;
    logic [DATA_W-1:0]  rdata_q;

    id_t                head_id;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant is combinational so a lone requester is served in its request cycle.
    // While reset is high nothing is granted, so every master sees waitrequest.
    always_comb begin
        grant       = M_CPU;
        grant_valid = 1'b0;
        if (!reset) begin
            if (state == ST_LOCKED) begin
                grant       = lock_id;
                grant_valid = 1'b1;
            end else if (req0 && req1) begin
                grant       = ~last_grant;
                grant_valid = 1'b1;
            end else if (req0) begin
                grant       = M_CPU;
                grant_valid = 1'b1;
            end else if (req1) begin
                grant       = M_AUX;
                grant_valid = 1'b1;
            end
        end
    end

    assign g_read  = grant_valid & ((grant == M_CPU) ? m0_read  : m1_read);
    assign g_write = grant_valid & ((grant == M_CPU) ? m0_write : m1_write);

    assign rdv_pop   = s_readdatavalid & !fifo_empty;
    assign rdv_unexp = s_readdatavalid & (fifo_count == '0);

    // A full tracker still admits a read when a beat retires in the same cycle.
    assign read_blocked = g_read & fifo_full & !rdv_pop;

    assign s_read  = g_read & !read_blocked;
    assign s_write = g_write;
    assign accept  = (s_read | s_write) & !s_waitrequest;

    always_comb begin
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        if (grant_valid) begin
            if (grant == M_CPU) begin
                s_address    = m0_address;
                s_writedata  = m0_writedata;
                s_byteenable = m0_byteenable;
            end else begin
                s_address    = m1_address;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
            end
        end
    end

    assign m0_waitrequest = !(grant_valid && (grant == M_CPU) && !read_blocked && !s_waitrequest);
    assign m1_waitrequest = !(grant_valid && (grant == M_AUX) && !read_blocked && !s_waitrequest);

    arb_id_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (s_read & !s_waitrequest),
        .push_id (grant),
        .pop     (rdv_pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_OPEN;
            lock_id          <= M_CPU;
            last_grant       <= M_AUX;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            rdata_q          <= '0;
            err_unexp_rdv    <= 1'b0;
        end else begin
            case (state)
                ST_OPEN: begin
                    if (accept) begin
                        last_grant <= grant;
                    end else if (s_read || s_write) begin
                        state   <= ST_LOCKED;
                        lock_id <= grant;
                    end
                end
                ST_LOCKED: begin
                    if (accept) begin
                        state      <= ST_OPEN;
                        last_grant <= grant;
                    end
                end
                default: state <= ST_OPEN;
            endcase

            m0_readdatavalid <= rdv_pop & (head_id == M_CPU);
            m1_readdatavalid <= rdv_pop & (head_id == M_AUX);
            if (s_readdatavalid) begin
                rdata_q <= s_readdata;
            end
            if (rdv_unexp) begin
                err_unexp_rdv <= 1'b1;
            end
        end
    end

    // Read data is broadcast; only the valid strobe is steered.
    assign m0_readdata = rdata_q;
    assign m1_readdata = rdata_q;

endmodule
